// File: rtl/axi_wr_arbiter.sv
// rtl/axi_wr_arbiter.sv - two-requester round-robin arbiter onto a single AXI write port
// Bursts are serialised: address, data pass-through, then response, one owner at a time.
module axi_wr_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            aclk,
  input  logic            resetn,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [2*AW-1:0] req_addr,
  input  logic [15:0]     req_len,
  input  logic [1:0]      wr_valid,
  output logic [1:0]      wr_ready,
  input  logic [2*DW-1:0] wr_data,
  output logic [1:0]      done_valid,
  output logic [1:0]      done_resp,
  output logic [1:0]      grant,
  output logic            awvalid,
  input  logic            awready,
  output logic [AW-1:0]   awaddr,
  output logic [7:0]      awlen,
  output logic            wvalid,
  input  logic            wready,
  output logic [DW-1:0]   wdata,
  output logic            wlast,
  input  logic            bvalid,
  output logic            bready,
  input  logic [1:0]      bresp
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  logic [1:0]    state_q, state_d;
  logic          ptr_q, ptr_d;
  logic          gidx_q, gidx_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    len_q, len_d;
  logic          awvalid_q, awvalid_d;
  logic [7:0]    beat_q, beat_d;
  logic [1:0]    grant_q, grant_d;
  logic [1:0]    done_valid_q, done_valid_d;
  logic [1:0]    done_resp_q, done_resp_d;

  logic          win;
  logic          win_valid;
  logic          in_idle;
  logic          in_data;
  logic          w_hs;
  logic [AW-1:0] win_addr;
  logic [7:0]    win_len;

  // The pointer side wins ties; otherwise whichever requester is asking.
  always_comb begin
    win       = req_valid[ptr_q] ? ptr_q : ~ptr_q;
    win_valid = req_valid[win];
    win_addr  = win ? req_addr[AW +: AW] : req_addr[0 +: AW];
    win_len   = win ? req_len[8 +: 8] : req_len[0 +: 8];
    in_idle   = (state_q == IDLE);
    in_data   = (state_q == DATA);
  end

  always_comb begin
    req_ready = 2'b00;
    if (in_idle && win_valid) req_ready[win] = 1'b1;
  end

  always_comb begin
    wr_ready = 2'b00;
    if (in_data) wr_ready[gidx_q] = wready;
    wvalid = in_data && wr_valid[gidx_q];
    wdata  = gidx_q ? wr_data[DW +: DW] : wr_data[0 +: DW];
    wlast  = in_data && (beat_q == len_q);
    bready = (state_q == RESP);
    w_hs   = wvalid && wready;
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    gidx_d       = gidx_q;
    addr_d       = addr_q;
    len_d        = len_q;
    awvalid_d    = awvalid_q;
    beat_d       = beat_q;
    grant_d      = grant_q;
    done_valid_d = 2'b00;
    done_resp_d  = done_resp_q;
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          state_d   = ADDR;
          gidx_d    = win;
          addr_d    = win_addr;
          len_d     = win_len;
          awvalid_d = 1'b1;
          grant_d   = win ? 2'b10 : 2'b01;
        end
      end
      ADDR: begin
        if (awvalid_q && awready) begin
          state_d   = DATA;
          awvalid_d = 1'b0;
          beat_d    = 8'd0;
        end
      end
      DATA: begin
        // Counter stops at len on the last beat, so a 256-beat burst never wraps.
        if (w_hs) begin
          if (wlast) state_d = RESP;
          else       beat_d  = beat_q + 8'd1;
        end
      end
      RESP: begin
        if (bvalid) begin
          state_d      = IDLE;
          done_valid_d = gidx_q ? 2'b10 : 2'b01;
          done_resp_d  = bresp;
          ptr_d        = ~gidx_q;
          grant_d      = 2'b00;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!resetn) begin
      state_q      <= IDLE;
      ptr_q        <= 1'b0;
      gidx_q       <= 1'b0;
      addr_q       <= '0;
      len_q        <= '0;
      awvalid_q    <= 1'b0;
      beat_q       <= '0;
      grant_q      <= 2'b00;
      done_valid_q <= 2'b00;
      done_resp_q  <= 2'b00;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      gidx_q       <= gidx_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      awvalid_q    <= awvalid_d;
      beat_q       <= beat_d;
      grant_q      <= grant_d;
      done_valid_q <= done_valid_d;
      done_resp_q  <= done_resp_d;
    end
  end

  assign awvalid    = awvalid_q;
  assign awaddr     = addr_q;
  assign awlen      = len_q;
  assign grant      = grant_q;
  assign done_valid = done_valid_q;
  assign done_resp  = done_resp_q;

endmodule

// File: doc/axi_wr_arbiter.md
AXI_WR_ARBITER -- requirements
Module: axi_wr_arbiter

Interface
REQ-001 Parameters SHALL be: AW, 32, address width; DW, 32, data width.
REQ-002 aclk  input  1  clock; all state SHALL change on its rising edge.
REQ-003 resetn  input  1  reset; resetn SHALL be synchronous and active-low.
REQ-004 req_valid  input  2  per-requester burst command valid (bit i = requester i).
REQ-005 req_ready  output  2  per-requester command accept.
REQ-006 req_addr  input  2*AW  start address; requester i at bits [i*AW +: AW].
REQ-007 req_len  input  2*8  burst length minus one; requester i at bits [i*8 +: 8].
REQ-008 wr_valid  input  2  per-requester write-data beat valid.
REQ-009 wr_ready  output  2  per-requester write-data beat accept.
REQ-010 wr_data  input  2*DW  write data; requester i at bits [i*DW +: DW].
REQ-011 done_valid  output  2  one-cycle pulse: requester i's burst completed.
REQ-012 done_resp  output  2  write response for the completed burst.
REQ-013 grant  output  2  one-hot owner of the AXI write port; 00 when idle.
REQ-014 awvalid/awready/awaddr(AW)/awlen(8): AXI write-address channel. awvalid, awaddr and awlen are outputs; awready is an input.
REQ-015 wvalid/wready/wdata(DW)/wlast: AXI write-data channel. wvalid, wdata and wlast are outputs; wready is an input.
REQ-016 bvalid/bready/bresp(2): AXI write-response channel. bvalid and bresp are inputs; bready is an output.

Function
REQ-017 The FSM SHALL have exactly four states: IDLE, ADDR, DATA and RESP.
REQ-018 Arbitration in IDLE:
- A 1-bit round-robin pointer ptr SHALL select the winner.
- The winner SHALL be ptr if req_valid[ptr]=1; otherwise it SHALL be the other requester if that requester's req_valid=1.
REQ-019 req_ready SHALL be combinational: req_ready[i]=1 only while in IDLE, when i is the winner and req_valid[i]=1.
REQ-020 On acceptance, the block SHALL latch the winner index, req_addr and req_len, set grant to the winner, and enter ADDR on the next cycle.
REQ-021 In ADDR, the address channel SHALL behave as follows:
- awvalid=1, driven from a register.
- awaddr and awlen SHALL hold the latched values.
- awvalid SHALL be held until awready=1.
- On the awvalid&&awready handshake, the FSM SHALL go to DATA and awvalid SHALL be 0 on the next cycle.
REQ-022 In DATA, the granted requester g SHALL be passed through combinationally: wvalid=wr_valid[g], wdata=wr_data[g], wr_ready[g]=wready.
REQ-023 wr_ready of the ungranted requester SHALL be 0 at all times. All wr_ready bits SHALL be 0 outside DATA.
REQ-024 An 8-bit beat counter SHALL:
- clear on entering DATA;
- increment on each wvalid&&wready.
REQ-025 wlast SHALL equal (beat counter == latched len) while in DATA, and SHALL be 0 otherwise.
REQ-026 The handshake with wlast=1 SHALL move the FSM to RESP. A burst SHALL be exactly len+1 beats (1 to 256 beats); the counter SHALL never wrap.
REQ-027 In RESP, bready SHALL be 1. bready SHALL be 0 in all other states.
REQ-028 On bvalid&&bready, on the next cycle:
- done_valid[g]=1 for exactly one cycle;
- done_resp=bresp, registered;
- ptr SHALL become the other requester;
- grant SHALL become 00;
- the state SHALL become IDLE.
REQ-029 bresp values SLVERR and DECERR SHALL be forwarded unchanged; the block SHALL NOT retry.
REQ-030 A new grant SHALL be allowed in the same cycle that done_valid pulses.
REQ-031 Minimum latency:
- request accepted at cycle T;
- awvalid=1 at T+1;
- first W beat is possible at T+2;
- done_valid at (B handshake cycle)+1.
REQ-032 Requesters SHALL hold wr_valid and wr_data stable until wr_ready=1. The block does not buffer W data.
REQ-033 A requester's req_valid arriving while the port is busy SHALL wait, with req_ready=0 and no loss of the request.

Reset
REQ-034 While resetn=0 at a rising edge, the block SHALL set:
- state=IDLE, ptr=0, beat counter=0;
- awvalid=0, awaddr=0, awlen=0;
- grant=00, done_valid=00, done_resp=00.
REQ-035 Reset asserted mid-burst SHALL abandon the burst, with no done_valid pulse. All combinational outputs SHALL then evaluate as in IDLE.

Verification
REQ-036 Single burst:
- Stimulus: req0 with addr=0x100, len=3; wready=1; bvalid 2 cycles after wlast.
- Required: awaddr=0x100 and awlen=3; 4 beats with wlast on beat 4 only; done_valid=01 with done_resp=00.
REQ-037 Simultaneous requests after reset:
- Stimulus: req0 and req1 both valid.
- Required: requester 0 is granted first; requester 1 is granted immediately after done_valid[0]; ptr=0 after both complete.
REQ-038 Backpressure:
- Stimulus: awready low for 5 cycles; wready toggling every cycle; len=7.
- Required: awvalid held stable; exactly 8 beats; wr_ready[1]=0 throughout.
REQ-039 Error response:
- Stimulus: bresp=2'b10 on requester 1's burst.
- Required: done_resp=10 and done_valid=10 for one cycle; no retry.
REQ-040 Reset mid-DATA:
- Stimulus: resetn=0 after beat 2 of a len=255 burst.
- Required: next cycle awvalid=0, wvalid=0, bready=0, grant=00, no done_valid; a fresh req0 then completes normally.
REQ-041 Maximum length:
- Stimulus: len=255.
- Required: 256 beats; wlast only on beat 256.
